// File: rtl/spi_master_cpha0.sv
// rtl/spi_master_cpha0.sv - SPI mode-0 master with byte valid/ready front end and ssel bursts
// Optional build macro: SPIM_LSB_FIRST_EN (shift bit 0 first on mosi and fill rx_data from bit 0 up)
module spi_master_cpha0 #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_last,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_busy,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_ssel,
    input  logic       i_miso
);

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_NEXT,
        S_HOLD,
        S_DESEL
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_shift;
    logic       r_last;
    logic       r_miso_meta;
    logic       r_miso_sync;
    logic       r_tx_ready;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_busy;
    logic       r_sck;
    logic       r_mosi;
    logic       r_ssel;

    logic       w_first_bit;
    logic       w_next_bit;
    logic [7:0] w_tx_shifted;
    logic [7:0] w_rx_next;

`ifdef SPIM_LSB_FIRST_EN
    assign w_first_bit  = i_tx_data[0];
    assign w_next_bit   = r_tx_shift[1];
    assign w_tx_shifted = {1'b0, r_tx_shift[7:1]};
    assign w_rx_next    = {r_miso_sync, r_rx_shift[7:1]};
`else
    assign w_first_bit  = i_tx_data[7];
    assign w_next_bit   = r_tx_shift[6];
    assign w_tx_shifted = {r_tx_shift[6:0], 1'b0};
    assign w_rx_next    = {r_rx_shift[6:0], r_miso_sync};
`endif

    assign o_tx_ready = r_tx_ready;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;
    assign o_busy     = r_busy;
    assign o_sck      = r_sck;
    assign o_mosi     = r_mosi;
    assign o_ssel     = r_ssel;

    // Two-flop synchroniser for the asynchronous miso line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= i_miso;
            r_miso_sync <= r_miso_meta;
        end
    end

    // Transfer sequencer: phase timing, bit shifting and all registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_bit      <= 3'd0;
            r_tx_shift <= 8'd0;
            r_rx_shift <= 8'd0;
            r_last     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'd0;
            r_busy     <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_ssel     <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_tx_valid) begin
                        r_tx_shift <= i_tx_data;
                        r_last     <= i_tx_last;
                        r_mosi     <= w_first_bit;
                        r_ssel     <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bit      <= 3'd0;
                        r_cnt      <= SETUP_M1;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == 8'd0) begin
                        r_cnt   <= DIV_M1;
                        r_state <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_LOW: begin
                    if (r_cnt == 8'd0) begin
                        r_sck   <= 1'b1;
                        r_cnt   <= DIV_M1;
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == 8'd0) begin
                        // Last cycle of the high phase: capture miso and drop sck
                        r_sck      <= 1'b0;
                        r_rx_shift <= w_rx_next;
                        r_bit      <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            if (r_last) begin
                                r_cnt   <= HOLD_M1;
                                r_state <= S_HOLD;
                            end else begin
                                r_tx_ready <= 1'b1;
                                r_state    <= S_NEXT;
                            end
                        end else begin
                            r_mosi     <= w_next_bit;
                            r_tx_shift <= w_tx_shifted;
                            r_cnt      <= DIV_M1;
                            r_state    <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_NEXT: begin
                    // ssel stays low; the next byte skips the setup delay
                    if (i_tx_valid) begin
                        r_tx_shift <= i_tx_data;
                        r_last     <= i_tx_last;
                        r_mosi     <= w_first_bit;
                        r_tx_ready <= 1'b0;
                        r_cnt      <= DIV_M1;
                        r_state    <= S_LOW;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_ssel  <= 1'b1;
                        r_cnt   <= HOLD_M1;
                        r_state <= S_DESEL;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DESEL: begin
                    if (r_cnt == 8'd0) begin
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cpha0.sv
// tb/tb_spi_master_cpha0.sv - directed self-checking bench for spi_master_cpha0
module tb_spi_master_cpha0;

`ifdef SPIM_LSB_FIRST_EN
    localparam int P_DIV   = 2;
    localparam int P_SETUP = 1;
    localparam bit P_LSB   = 1'b1;
`else
    localparam int P_DIV   = 4;
    localparam int P_SETUP = 2;
    localparam bit P_LSB   = 1'b0;
`endif
    localparam int P_HOLD = 2;
    localparam int T_BYTE = 16 * P_DIV;

    logic       clk;
    logic       rst_n;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] i_tx_data;
    logic       i_tx_last;
    logic       o_rx_valid;
    logic [7:0] o_rx_data;
    logic       o_busy;
    logic       o_sck;
    logic       o_mosi;
    logic       o_ssel;
    logic       i_miso;
    logic       loop_en;
    logic       miso_fix;

    assign i_miso = loop_en ? o_mosi : miso_fix;

    spi_master_cpha0 #(
        .CLK_DIV (P_DIV),
        .CS_SETUP(P_SETUP),
        .CS_HOLD (P_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready),
        .i_tx_data (i_tx_data),
        .i_tx_last (i_tx_last),
        .o_rx_valid(o_rx_valid),
        .o_rx_data (o_rx_data),
        .o_busy    (o_busy),
        .o_sck     (o_sck),
        .o_mosi    (o_mosi),
        .o_ssel    (o_ssel),
        .i_miso    (i_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    int         sck_rises;
    int         first_rise;
    int         mosi_bad;
    int         mosi_high;
    int         ssel_falls;
    int         ssel_rises;
    int         ssel_fall_cyc;
    int         ssel_rise_cyc;
    int         ready_rise_cyc;
    logic [7:0] mosi_cap;
    int         rx_cyc_q[$];
    logic [7:0] rx_dat_q[$];
    logic [7:0] cap_q[$];
    logic       m_sck  = 1'b0;
    logic       m_mosi = 1'b0;
    logic       m_ssel = 1'b1;
    logic       m_rdy  = 1'b1;

    always @(negedge clk) begin
        if (o_sck && !m_sck) begin
            sck_rises++;
            if (first_rise < 0) first_rise = cyc;
            mosi_cap = {mosi_cap[6:0], o_mosi};
        end
        if (o_sck && (o_mosi != m_mosi)) mosi_bad++;
        if (o_mosi) mosi_high++;
        if (!o_ssel && m_ssel) begin
            ssel_falls++;
            ssel_fall_cyc = cyc;
        end
        if (o_ssel && !m_ssel) begin
            ssel_rises++;
            ssel_rise_cyc = cyc;
        end
        if (o_tx_ready && !m_rdy) ready_rise_cyc = cyc;
        if (o_rx_valid) begin
            rx_cyc_q.push_back(cyc);
            rx_dat_q.push_back(o_rx_data);
            cap_q.push_back(mosi_cap);
        end
        m_sck  = o_sck;
        m_mosi = o_mosi;
        m_ssel = o_ssel;
        m_rdy  = o_tx_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] wire_order(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7 - i];
        return P_LSB ? r : d;
    endfunction

    task automatic clear_mon();
        sck_rises      = 0;
        first_rise     = -1;
        mosi_bad       = 0;
        mosi_high      = 0;
        ssel_falls     = 0;
        ssel_rises     = 0;
        ssel_fall_cyc  = -1;
        ssel_rise_cyc  = -1;
        ready_rise_cyc = -1;
        rx_cyc_q.delete();
        rx_dat_q.delete();
        cap_q.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic last, output int e);
        e = -1;
        @(negedge clk);
        i_tx_valid = 1'b1;
        i_tx_data  = d;
        i_tx_last  = last;
        for (int k = 0; k < 500; k++) begin
            if (o_tx_ready) begin
                @(posedge clk);
                #1;
                e = cyc;
                break;
            end
            @(negedge clk);
        end
        if (e < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_rx(input int n);
        int k;
        for (k = 0; k < 400 && rx_cyc_q.size() < n; k++) @(negedge clk);
        if (rx_cyc_q.size() < n) check("rx_timeout", rx_cyc_q.size(), n);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400 && o_busy; k++) @(negedge clk);
        if (o_busy) check("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    int e0, e1, e2;
    int bad;

    initial begin
        rst_n      = 1'b0;
        i_tx_valid = 1'b0;
        i_tx_data  = 8'h00;
        i_tx_last  = 1'b0;
        loop_en    = 1'b1;
        miso_fix   = 1'b0;
        mosi_cap   = 8'h00;
        clear_mon();
        repeat (3) @(negedge clk);

        check("rst_ssel", o_ssel, 1);
        check("rst_sck", o_sck, 0);
        check("rst_mosi", o_mosi, 0);
        check("rst_rx_valid", o_rx_valid, 0);
        check("rst_rx_data", o_rx_data, 8'h00);
        check("rst_tx_ready", o_tx_ready, 1);
        check("rst_busy", o_busy, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single loopback byte with tx_last
        clear_mon();
        send(8'hA5, 1'b1, e0);
        i_tx_valid = 1'b0;
        check("a5_ssel_low", o_ssel, 0);
        check("a5_first_mosi", o_mosi, 1);
        wait_rx(1);
        wait_idle();
        check("a5_rx_data", rx_dat_q[0], 8'hA5);
        check("a5_rx_time", rx_cyc_q[0] - e0, P_SETUP + T_BYTE);
        check("a5_first_rise", first_rise - e0, P_SETUP + P_DIV);
        check("a5_sck_rises", sck_rises, 8);
        check("a5_ssel_low_len", ssel_rise_cyc - ssel_fall_cyc, P_SETUP + T_BYTE + P_HOLD);
        check("a5_ready_time", ready_rise_cyc - e0, P_SETUP + T_BYTE + 2 * P_HOLD);
        check("a5_rx_count", rx_cyc_q.size(), 1);

        // Three-byte burst with tx_valid held high
        clear_mon();
        send(8'h01, 1'b0, e0);
        check("burst_first_mosi", o_mosi, P_LSB ? 1 : 0);
        send(8'h80, 1'b0, e1);
        send(8'hFF, 1'b1, e2);
        i_tx_valid = 1'b0;
        wait_rx(3);
        wait_idle();
        check("burst_rx_count", rx_cyc_q.size(), 3);
        check("burst_rx0", rx_dat_q[0], 8'h01);
        check("burst_rx1", rx_dat_q[1], 8'h80);
        check("burst_rx2", rx_dat_q[2], 8'hFF);
        check("burst_gap01", rx_cyc_q[1] - rx_cyc_q[0], T_BYTE + 1);
        check("burst_gap12", rx_cyc_q[2] - rx_cyc_q[1], T_BYTE + 1);
        check("burst_rx1_time", rx_cyc_q[1] - e1, T_BYTE);
        check("burst_sck_rises", sck_rises, 24);
        check("burst_ssel_falls", ssel_falls, 1);
        check("burst_ssel_rises", ssel_rises, 1);
        check("burst_mosi_order", cap_q[0], wire_order(8'h01));
        check("burst_mosi_stable", mosi_bad, 0);

        // miso tied high while sending zeros
        loop_en  = 1'b0;
        miso_fix = 1'b1;
        send(8'h00, 1'b1, e0);
        i_tx_valid = 1'b0;
        clear_mon();
        wait_rx(1);
        wait_idle();
        check("ones_rx_data", rx_dat_q[0], 8'hFF);
        check("ones_mosi_high", mosi_high, 0);

        // Burst stall in NEXT
        loop_en = 1'b1;
        clear_mon();
        send(8'h5A, 1'b0, e0);
        i_tx_valid = 1'b0;
        wait_rx(1);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_ssel !== 1'b0 || o_sck !== 1'b0 || o_tx_ready !== 1'b1) bad++;
        end
        check("stall_bus", bad, 0);
        first_rise = -1;
        send(8'hC6, 1'b1, e1);
        i_tx_valid = 1'b0;
        wait_rx(2);
        wait_idle();
        check("stall_first_rise", first_rise - e1, P_DIV);
        check("stall_rx0", rx_dat_q[0], 8'h5A);
        check("stall_rx1", rx_dat_q[1], 8'hC6);
        check("stall_rx1_time", rx_cyc_q[1] - e1, T_BYTE);
        check("stall_mosi_order", cap_q[1], wire_order(8'hC6));
        check("stall_ssel_falls", ssel_falls, 1);

        // Asynchronous reset part-way through a byte
        clear_mon();
        send(8'hF7, 1'b1, e0);
        i_tx_valid = 1'b0;
        repeat (31) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ssel", o_ssel, 1);
        check("arst_sck", o_sck, 0);
        check("arst_mosi", o_mosi, 0);
        check("arst_busy", o_busy, 0);
        check("arst_tx_ready", o_tx_ready, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("arst_no_rx", rx_cyc_q.size(), 0);
        send(8'h3C, 1'b1, e0);
        i_tx_valid = 1'b0;
        wait_rx(1);
        wait_idle();
        check("arst_after_data", rx_dat_q[0], 8'h3C);
        check("arst_after_time", rx_cyc_q[0] - e0, P_SETUP + T_BYTE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
